// File: rtl/mux_frame_collector.sv
// ---------------------------------------------------------------------------
// mux_frame_collector
//
// Collects ADC samples taken behind a two-level analogue multiplexer and
// reassembles them into 16-channel frames. Each frame is 18 strobed slots:
// slot 0 carries a rotating marker code (3,5,2,5) on muxHigh, slots 1..16
// carry channel samples, and slot 17 is an end marker (muxHigh=4).
// The block hunts for a marker, verifies LOCK_FRAMES further frames, and
// only then emits channel samples.
//
// Ports
//   clk          : single clock, all logic on its rising edge
//   reset        : asynchronous active-low reset
//   sampleStrobe : one-cycle pulse qualifying sampleData/muxLow/muxHigh
//   sampleData   : ADC sample (DATA_W bits)
//   muxLow       : first-level mux address (3 bits)
//   muxHigh      : second-level mux address (3 bits)
//   outValid     : one-cycle pulse, outChannel/outData valid
//   outChannel   : channel number 1..16, holds between pulses
//   outData      : sample for outChannel, holds between pulses
//   frameStart   : one-cycle pulse on an accepted marker while locked
//   locked       : high in LOCKED
//   state        : HUNT=0, VERIFY=1, LOCKED=2
//   errCount     : saturating count of sequence errors
// ---------------------------------------------------------------------------
module mux_frame_collector #(
  parameter int DATA_W      = 12,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sampleStrobe,
  input  logic [DATA_W-1:0] sampleData,
  input  logic [2:0]        muxLow,
  input  logic [2:0]        muxHigh,
  output logic              outValid,
  output logic [4:0]        outChannel,
  output logic [DATA_W-1:0] outData,
  output logic              frameStart,
  output logic              locked,
  output logic [1:0]        state,
  output logic [7:0]        errCount
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [2:0] LOCK_CNT = 3'(LOCK_FRAMES);

  // Marker code expected on muxHigh for each rotation index.
  function automatic logic [2:0] marker_of(input logic [1:0] idx);
    logic [2:0] m;
    case (idx)
      2'd0:    m = 3'd3;
      2'd1:    m = 3'd5;
      2'd2:    m = 3'd2;
      default: m = 3'd5;
    endcase
    return m;
  endfunction

  // True when the strobed address lines match what slot s expects.
  // For slots 1..8 and 9..16 the expected muxLow is (s-1) and (s-9)
  // respectively; both reduce to s[2:0]-1 modulo 8.
  function automatic logic slot_match(input logic [4:0] s,
                                      input logic [1:0] idx,
                                      input logic [2:0] hi,
                                      input logic [2:0] lo);
    logic m;
    m = 1'b0;
    if (s == 5'd0) begin
      m = (hi == marker_of(idx));
    end else if (s <= 5'd8) begin
      m = (hi == 3'd0) && (lo == (s[2:0] - 3'd1));
    end else if (s <= 5'd16) begin
      m = (hi == 3'd1) && (lo == (s[2:0] - 3'd1));
    end else if (s == 5'd17) begin
      m = (hi == 3'd4);
    end else begin
      m = 1'b0;
    end
    return m;
  endfunction

  state_e              state_q, state_d;
  logic [4:0]          slot_q, slot_d;
  logic [1:0]          idx_q, idx_d;
  logic [2:0]          good_q, good_d;
  logic [7:0]          err_q, err_d;
  logic                valid_q, valid_d;
  logic                fs_q, fs_d;
  logic [4:0]          ch_q, ch_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                match_s;
  logic [4:0]          slot_next_s;

  // Next-state and output decode; every strobe is judged against the
  // state held before this edge.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    idx_d       = idx_q;
    good_d      = good_q;
    err_d       = err_q;
    valid_d     = 1'b0;
    fs_d        = 1'b0;
    ch_d        = ch_q;
    data_d      = data_q;
    match_s     = slot_match(slot_q, idx_q, muxHigh, muxLow);
    slot_next_s = (slot_q == 5'd17) ? 5'd0 : slot_q + 5'd1;

    if (sampleStrobe) begin
      case (state_q)
        HUNT: begin
          // Markers 3 and 2 are unambiguous in the sequence; 5 is not.
          if (muxHigh == 3'd3) begin
            idx_d   = 2'd1;
            slot_d  = 5'd1;
            good_d  = 3'd0;
            state_d = VERIFY;
          end else if (muxHigh == 3'd2) begin
            idx_d   = 2'd3;
            slot_d  = 5'd1;
            good_d  = 3'd0;
            state_d = VERIFY;
          end else begin
            state_d = HUNT;
          end
        end
        VERIFY, LOCKED: begin
          if (!match_s) begin
            state_d = HUNT;
            slot_d  = 5'd0;
            idx_d   = 2'd0;
            good_d  = 3'd0;
            if (err_q == 8'hFF) begin
              err_d = err_q;
            end else begin
              err_d = err_q + 8'd1;
            end
          end else begin
            slot_d = slot_next_s;
            if (slot_q == 5'd0) begin
              idx_d = idx_q + 2'd1;
              if (state_q == VERIFY) begin
                good_d = good_q + 3'd1;
                if ((good_q + 3'd1) == LOCK_CNT) begin
                  state_d = LOCKED;
                end else begin
                  state_d = VERIFY;
                end
              end else begin
                fs_d = 1'b1;
              end
            end else if ((slot_q <= 5'd16) && (state_q == LOCKED)) begin
              valid_d = 1'b1;
              ch_d    = slot_q;
              data_d  = sampleData;
            end else begin
              valid_d = 1'b0;
            end
          end
        end
        default: begin
          // Unused encoding: recover to a clean hunt.
          state_d = HUNT;
          slot_d  = 5'd0;
          idx_d   = 2'd0;
          good_d  = 3'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HUNT;
      slot_q  <= 5'd0;
      idx_q   <= 2'd0;
      good_q  <= 3'd0;
      err_q   <= 8'd0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      ch_q    <= 5'd0;
      data_q  <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      good_q  <= good_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
    end
  end

  assign outValid   = valid_q;
  assign outChannel = ch_q;
  assign outData    = data_q;
  assign frameStart = fs_q;
  assign locked     = (state_q == LOCKED);
  assign state      = state_q;
  assign errCount   = err_q;

endmodule
